// File: rtl/seg_display_pkg.sv
// Shared field layout, reset constants and seven-segment glyphs for the
// Avalon seven-segment display controller.
package seg_display_pkg;

  typedef logic [6:0] seg7_t;

  // DIGITn register layout
  localparam int DIGIT_HEX_LSB   = 0;
  localparam int DIGIT_HEX_W     = 4;
  localparam int DIGIT_RAW_BIT   = 4;
  localparam int DIGIT_SEG_LSB   = 8;
  localparam int DIGIT_SEG_W     = 7;
  localparam int DIGIT_BLANK_BIT = 16;
  localparam int DIGIT_BLINK_BIT = 17;
  localparam logic [31:0] DIGIT_WR_MASK = 32'h0003_7F1F;

  // CTRL register layout
  localparam int CTRL_BRIGHT_LSB = 0;
  localparam int CTRL_EN_BIT     = 8;
  localparam int CTRL_PHASE_BIT  = 9;

  localparam logic [31:0] DIGIT_RST      = 32'h0000_0000;
  localparam logic        CTRL_EN_RST    = 1'b1;
  localparam logic        CTRL_PHASE_RST = 1'b0;

  // Active-high glyphs, bit0 = segment a .. bit6 = segment g
  localparam seg7_t SEG_HEX_0 = 7'h3F;
  localparam seg7_t SEG_HEX_1 = 7'h06;
  localparam seg7_t SEG_HEX_2 = 7'h5B;
  localparam seg7_t SEG_HEX_3 = 7'h4F;
  localparam seg7_t SEG_HEX_4 = 7'h66;
  localparam seg7_t SEG_HEX_5 = 7'h6D;
  localparam seg7_t SEG_HEX_6 = 7'h7D;
  localparam seg7_t SEG_HEX_7 = 7'h07;
  localparam seg7_t SEG_HEX_8 = 7'h7F;
  localparam seg7_t SEG_HEX_9 = 7'h6F;
  localparam seg7_t SEG_HEX_A = 7'h77;
  localparam seg7_t SEG_HEX_B = 7'h7C;
  localparam seg7_t SEG_HEX_C = 7'h39;
  localparam seg7_t SEG_HEX_D = 7'h5E;
  localparam seg7_t SEG_HEX_E = 7'h79;
  localparam seg7_t SEG_HEX_F = 7'h71;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high seven-segment glyph.
module seg7_hex_decode
  import seg_display_pkg::*;
(
  input  logic [3:0] hex_i,
  output seg7_t      seg_o
);

  always_comb begin
    case (hex_i)
      4'h0:    seg_o = SEG_HEX_0;
      4'h1:    seg_o = SEG_HEX_1;
      4'h2:    seg_o = SEG_HEX_2;
      4'h3:    seg_o = SEG_HEX_3;
      4'h4:    seg_o = SEG_HEX_4;
      4'h5:    seg_o = SEG_HEX_5;
      4'h6:    seg_o = SEG_HEX_6;
      4'h7:    seg_o = SEG_HEX_7;
      4'h8:    seg_o = SEG_HEX_8;
      4'h9:    seg_o = SEG_HEX_9;
      4'hA:    seg_o = SEG_HEX_A;
      4'hB:    seg_o = SEG_HEX_B;
      4'hC:    seg_o = SEG_HEX_C;
      4'hD:    seg_o = SEG_HEX_D;
      4'hE:    seg_o = SEG_HEX_E;
      default: seg_o = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/avalon_seg_display_ctrl_de1soc.sv
// Avalon-MM slave driving NUM_SEGMENT seven-segment digits with readback,
// raw/blank/blink per digit, global enable, PWM brightness and pin polarity.
module avalon_seg_display_ctrl_de1soc
  import seg_display_pkg::*;
#(
  parameter int NUM_SEGMENT = 6,
  parameter int ADDR_W      = $clog2(NUM_SEGMENT + 1),
  parameter int BLINK_DIV   = 25_000_000,
  parameter int PWM_W       = 4,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        avms_address_i,
  input  logic [3:0]               avms_byteenable_i,
  input  logic                     avms_write_i,
  input  logic [31:0]              avms_writedata_i,
  input  logic                     avms_read_i,
  output logic [31:0]              avms_readdata_o,
  output logic                     avms_readdatavalid_o,
  output logic [NUM_SEGMENT*7-1:0] segment_symbol_o
);

  localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [31:0]              digit_q [NUM_SEGMENT];
  logic [31:0]              digit_d [NUM_SEGMENT];
  logic [PWM_W-1:0]         bright_q, bright_d;
  logic                     en_q, en_d;
  logic                     phase_q, phase_d;
  logic [BLINK_W-1:0]       blink_cnt_q, blink_cnt_d;
  logic [PWM_W-1:0]         pwm_cnt_q, pwm_cnt_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     rvalid_q;
  logic [NUM_SEGMENT*7-1:0] seg_q, seg_d;
  logic [31:0]              be_mask;
  logic [31:0]              rd_mux;
  logic                     ctrl_sel;
  logic                     blink_wrap;
  logic                     pwm_on;
  seg7_t                    pattern [NUM_SEGMENT];

  assign ctrl_sel   = (avms_address_i == ADDR_W'(NUM_SEGMENT));
  assign blink_wrap = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
  assign pwm_on     = (pwm_cnt_q < bright_q) || (&bright_q);

  always_comb begin
    for (int b = 0; b < 4; b++) be_mask[8*b +: 8] = {8{avms_byteenable_i[b]}};
  end

  // Register file update; unmapped bits are stripped on the way in so readback stays clean
  always_comb begin
    for (int i = 0; i < NUM_SEGMENT; i++) begin
      digit_d[i] = digit_q[i];
      if (avms_write_i && avms_address_i == ADDR_W'(i))
        digit_d[i] = (digit_q[i] & ~be_mask) | (avms_writedata_i & be_mask & DIGIT_WR_MASK);
    end
    bright_d = bright_q;
    en_d     = en_q;
    if (avms_write_i && ctrl_sel) begin
      if (avms_byteenable_i[0]) bright_d = avms_writedata_i[CTRL_BRIGHT_LSB +: PWM_W];
      if (avms_byteenable_i[1]) en_d = avms_writedata_i[CTRL_EN_BIT];
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_SEGMENT; i++)
      if (avms_address_i == ADDR_W'(i)) rd_mux = digit_q[i];
    if (ctrl_sel) begin
      rd_mux[CTRL_BRIGHT_LSB +: PWM_W] = bright_q;
      rd_mux[CTRL_EN_BIT]              = en_q;
      rd_mux[CTRL_PHASE_BIT]           = phase_q;
    end
  end

  always_comb begin
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
    phase_d     = blink_wrap ? ~phase_q : phase_q;
    pwm_cnt_d   = pwm_cnt_q + PWM_W'(1);
    rdata_d     = avms_read_i ? rd_mux : rdata_q;
  end

  for (genvar g = 0; g < NUM_SEGMENT; g++) begin : g_digit
    seg7_t hex_seg;
    logic  dark;

    seg7_hex_decode u_dec (
      .hex_i (digit_q[g][DIGIT_HEX_LSB +: DIGIT_HEX_W]),
      .seg_o (hex_seg)
    );

    assign dark = !en_q || digit_q[g][DIGIT_BLANK_BIT]
               || (digit_q[g][DIGIT_BLINK_BIT] && phase_q) || !pwm_on;
    assign pattern[g] = dark ? '0
                      : (digit_q[g][DIGIT_RAW_BIT] ? digit_q[g][DIGIT_SEG_LSB +: DIGIT_SEG_W] : hex_seg);
  end

  always_comb begin
    for (int i = 0; i < NUM_SEGMENT; i++)
      seg_d[7*i +: 7] = (ACTIVE_LOW != 0) ? ~pattern[i] : pattern[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SEGMENT; i++) digit_q[i] <= DIGIT_RST;
      bright_q    <= '1;
      en_q        <= CTRL_EN_RST;
      phase_q     <= CTRL_PHASE_RST;
      blink_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      seg_q       <= (ACTIVE_LOW != 0) ? '1 : '0;
    end else begin
      for (int i = 0; i < NUM_SEGMENT; i++) digit_q[i] <= digit_d[i];
      bright_q    <= bright_d;
      en_q        <= en_d;
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= avms_read_i;
      seg_q       <= seg_d;
    end
  end

  assign avms_readdata_o      = rdata_q;
  assign avms_readdatavalid_o = rvalid_q;
  assign segment_symbol_o     = seg_q;

endmodule
